// File: rtl/clk_src_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// clk_src_ctrl_pkg
//   Shared types and constants for the dual-MMCM clock-source sequencer.
//   - clk_src_state_t : 3-bit sequencer state encoding.
//   - SWITCH_CNT_W    : width of the ext<->int switch counter output.
// ---------------------------------------------------------------------------
package clk_src_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_LOCK  = 3'd1,
    S_INT   = 3'd2,
    S_EXT   = 3'd3,
    S_FAULT = 3'd4
  } clk_src_state_t;

  localparam int SWITCH_CNT_W = 16;

endpackage : clk_src_ctrl_pkg

// File: rtl/clk_src_sync2.sv
// ---------------------------------------------------------------------------
// clk_src_sync2
//   Two-flop synchronizer bringing an asynchronous level into the clk domain.
//   Both flops clear to 0 on rst.
// Ports:
//   clk  in  1  destination clock
//   rst  in  1  asynchronous active-high reset
//   d    in  1  asynchronous input level
//   q    out 1  synchronized level (2 clk cycles of latency)
// ---------------------------------------------------------------------------
module clk_src_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= 1'b0;
      q_reg    <= 1'b0;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule : clk_src_sync2

// File: rtl/clk_src_ctrl.sv
// ---------------------------------------------------------------------------
// clk_src_ctrl
//   Sequencer for the dual-MMCM clock-source mux. Holds the MMCMs in reset,
//   waits for lock (retrying on timeout, giving up into S_FAULT), runs on the
//   internal source and promotes to the external source only after a
//   stability window. Falls back to internal as soon as ext stops or
//   force_int is raised; a lock loss restarts the whole bring-up.
//
// Optional feature (macro CLK_SRC_CTRL_SWITCH_CNT_EN):
//   defined     -> switch_cnt counts S_INT<->S_EXT transitions, saturating.
//   not defined -> switch_cnt is tied to 0.
//
// Ports:
//   clk             in   1   free-running control clock
//   rst             in   1   asynchronous active-high reset
//   clk_ext_active  in   1   ext clock running flag (async, synchronized here)
//   locked          in   1   combined MMCM lock (async, synchronized here)
//   force_int       in   1   level, 1 = never select ext
//   retry           in   1   single-cycle pulse, leaves S_FAULT
//   mmcm_rst_n      out  1   0 = MMCMs held in reset
//   clk_int_select  out  1   1 = internal source selected
//   using_ext       out  1   1 while in S_EXT
//   fault           out  1   1 while in S_FAULT
//   state_o         out  3   current state encoding
//   switch_cnt      out  16  ext<->int switch count
// ---------------------------------------------------------------------------
module clk_src_ctrl
  import clk_src_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 4096,
  parameter int MAX_RETRY     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_ext_active,
  input  logic                    locked,
  input  logic                    force_int,
  input  logic                    retry,
  output logic                    mmcm_rst_n,
  output logic                    clk_int_select,
  output logic                    using_ext,
  output logic                    fault,
  output logic [2:0]              state_o,
  output logic [SWITCH_CNT_W-1:0] switch_cnt
);

  localparam int RST_W   = $clog2(RST_CYCLES + 1);
  localparam int LOCK_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int STAB_W  = $clog2(STABLE_CYCLES + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [LOCK_W-1:0]  LOCK_LAST = LOCK_W'(LOCK_TIMEOUT - 1);
  localparam logic [STAB_W-1:0]  STAB_MAX  = STAB_W'(STABLE_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  // ---- input synchronizers ------------------------------------------------
  logic ext_s;
  logic lock_s;

  clk_src_sync2 u_sync_ext (
    .clk (clk),
    .rst (rst),
    .d   (clk_ext_active),
    .q   (ext_s)
  );

  clk_src_sync2 u_sync_lock (
    .clk (clk),
    .rst (rst),
    .d   (locked),
    .q   (lock_s)
  );

  // ---- state and counters -------------------------------------------------
  clk_src_state_t     state_reg, state_next;
  logic [RST_W-1:0]   rst_cnt_reg, rst_cnt_next;
  logic [LOCK_W-1:0]  lock_cnt_reg, lock_cnt_next;
  logic [STAB_W-1:0]  stab_cnt_reg, stab_cnt_next;
  logic [RETRY_W-1:0] retry_cnt_reg, retry_cnt_next;

  logic rst_done;
  logic lock_expired;
  logic stab_full;
  logic retry_avail;

  assign rst_done     = (rst_cnt_reg == RST_LAST);
  assign lock_expired = (lock_cnt_reg == LOCK_LAST);
  assign stab_full    = (stab_cnt_reg == STAB_MAX);
  assign retry_avail  = (retry_cnt_reg < RETRY_MAX);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_RST;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. Check order encodes the event priority:
  // lock loss first, then ext loss / force_int, then stability promotion.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RST: begin
        if (rst_done) state_next = S_LOCK;
      end
      S_LOCK: begin
        if (lock_s)            state_next = S_INT;
        else if (lock_expired) state_next = retry_avail ? S_RST : S_FAULT;
      end
      S_INT: begin
        if (!lock_s)                     state_next = S_RST;
        else if (stab_full && !force_int) state_next = S_EXT;
      end
      S_EXT: begin
        if (!lock_s)                  state_next = S_RST;
        else if (!ext_s || force_int) state_next = S_INT;
      end
      S_FAULT: begin
        if (retry) state_next = S_RST;
      end
      default: state_next = S_RST;
    endcase
  end

  // Counter next values. Dwell counters restart whenever their state is
  // (re)entered; the stability window only accumulates while in S_INT, so
  // leaving S_INT for any reason discards it.
  always_comb begin
    rst_cnt_next   = '0;
    lock_cnt_next  = '0;
    stab_cnt_next  = '0;
    retry_cnt_next = retry_cnt_reg;

    if (state_reg == S_RST && state_next == S_RST)
      rst_cnt_next = rst_cnt_reg + RST_W'(1);

    if (state_reg == S_LOCK && state_next == S_LOCK)
      lock_cnt_next = lock_cnt_reg + LOCK_W'(1);

    if (state_reg == S_INT && ext_s)
      stab_cnt_next = stab_full ? stab_cnt_reg : stab_cnt_reg + STAB_W'(1);

    if (state_reg == S_LOCK) begin
      if (lock_s)
        retry_cnt_next = '0;
      else if (lock_expired && retry_avail)
        retry_cnt_next = retry_cnt_reg + RETRY_W'(1);
    end
    if (state_reg == S_FAULT && retry)
      retry_cnt_next = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_cnt_reg   <= '0;
      lock_cnt_reg  <= '0;
      stab_cnt_reg  <= '0;
      retry_cnt_reg <= '0;
    end else begin
      rst_cnt_reg   <= rst_cnt_next;
      lock_cnt_reg  <= lock_cnt_next;
      stab_cnt_reg  <= stab_cnt_next;
      retry_cnt_reg <= retry_cnt_next;
    end
  end

  // ---- registered outputs -------------------------------------------------
  // Decoded from state_next so the outputs change on the same edge as the
  // state register (sync 2 cycles + 1 decision cycle = 3-cycle response).
  logic mmcm_rst_n_reg, mmcm_rst_n_next;
  logic select_reg, select_next;
  logic using_ext_reg, using_ext_next;
  logic fault_reg, fault_next;

  always_comb begin
    mmcm_rst_n_next = (state_next != S_RST);
    select_next     = (state_next != S_EXT);
    using_ext_next  = (state_next == S_EXT);
    fault_next      = (state_next == S_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mmcm_rst_n_reg <= 1'b0;
      select_reg     <= 1'b1;
      using_ext_reg  <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      mmcm_rst_n_reg <= mmcm_rst_n_next;
      select_reg     <= select_next;
      using_ext_reg  <= using_ext_next;
      fault_reg      <= fault_next;
    end
  end

  assign mmcm_rst_n     = mmcm_rst_n_reg;
  assign clk_int_select = select_reg;
  assign using_ext      = using_ext_reg;
  assign fault          = fault_reg;
  assign state_o        = state_reg;

  // ---- optional switch counter --------------------------------------------
`ifdef CLK_SRC_CTRL_SWITCH_CNT_EN
  logic [SWITCH_CNT_W-1:0] switch_cnt_reg;
  logic                    is_switch;

  assign is_switch = ((state_reg == S_INT) && (state_next == S_EXT)) ||
                     ((state_reg == S_EXT) && (state_next == S_INT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      switch_cnt_reg <= '0;
    end else if (is_switch && (switch_cnt_reg != '1)) begin
      switch_cnt_reg <= switch_cnt_reg + SWITCH_CNT_W'(1);
    end
  end

  assign switch_cnt = switch_cnt_reg;
`else
  assign switch_cnt = '0;
`endif

endmodule : clk_src_ctrl

// File: tb/tb_clk_src_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_src_ctrl
//   Directed self-checking bench for clk_src_ctrl with
//   RST_CYCLES=8, LOCK_TIMEOUT=100, STABLE_CYCLES=16, MAX_RETRY=2.
//   Expected switch_cnt follows CLK_SRC_CTRL_SWITCH_CNT_EN.
// ---------------------------------------------------------------------------
module tb_clk_src_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_ext_active;
  logic        locked;
  logic        force_int;
  logic        retry;
  logic        mmcm_rst_n;
  logic        clk_int_select;
  logic        using_ext;
  logic        fault;
  logic [2:0]  state_o;
  logic [15:0] switch_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_sw   = 0;

  localparam logic [2:0] ST_RST   = 3'd0;
  localparam logic [2:0] ST_LOCK  = 3'd1;
  localparam logic [2:0] ST_INT   = 3'd2;
  localparam logic [2:0] ST_EXT   = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  always #5 clk = ~clk;

  clk_src_ctrl #(
    .RST_CYCLES    (8),
    .LOCK_TIMEOUT  (100),
    .STABLE_CYCLES (16),
    .MAX_RETRY     (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clk_ext_active (clk_ext_active),
    .locked         (locked),
    .force_int      (force_int),
    .retry          (retry),
    .mmcm_rst_n     (mmcm_rst_n),
    .clk_int_select (clk_int_select),
    .using_ext      (using_ext),
    .fault          (fault),
    .state_o        (state_o),
    .switch_cnt     (switch_cnt)
  );

  function automatic logic [15:0] sw_exp(input int n);
`ifdef CLK_SRC_CTRL_SWITCH_CNT_EN
    return 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; clk_ext_active = 1'b0; locked = 1'b0; force_int = 1'b0; retry = 1'b0;
    tick(2);
    n_checks++; if (state_o !== ST_RST) $display("FAIL reset_state got=%0d exp=%0d", state_o, ST_RST); else n_pass++;
    n_checks++; if (mmcm_rst_n !== 1'b0) $display("FAIL reset_mmcm_rst_n got=%b exp=0", mmcm_rst_n); else n_pass++;
    n_checks++; if (clk_int_select !== 1'b1) $display("FAIL reset_select got=%b exp=1", clk_int_select); else n_pass++;
    n_checks++; if (using_ext !== 1'b0 || fault !== 1'b0) $display("FAIL reset_flags got using_ext=%b fault=%b exp=0/0", using_ext, fault); else n_pass++;
    n_checks++; if (switch_cnt !== 16'd0) $display("FAIL reset_switch_cnt got=%0d exp=0", switch_cnt); else n_pass++;
    $display("reset: state=%0d mmcm_rst_n=%b select=%b", state_o, mmcm_rst_n, clk_int_select);
  endtask

  task automatic test_bringup;
    rst = 1'b0;
    tick(7);
    n_checks++; if (mmcm_rst_n !== 1'b0) $display("FAIL bringup_rst_low_7 got=%b exp=0", mmcm_rst_n); else n_pass++;
    tick(1);
    n_checks++; if (mmcm_rst_n !== 1'b1 || state_o !== ST_LOCK) $display("FAIL bringup_rst_release got mmcm_rst_n=%b state=%0d exp 1/%0d", mmcm_rst_n, state_o, ST_LOCK); else n_pass++;
    tick(12);
    locked = 1'b1;
    tick(2);
    n_checks++; if (state_o !== ST_LOCK) $display("FAIL bringup_lock_latency2 got=%0d exp=%0d", state_o, ST_LOCK); else n_pass++;
    tick(1);
    n_checks++; if (state_o !== ST_INT || clk_int_select !== 1'b1) $display("FAIL bringup_int got state=%0d select=%b exp %0d/1", state_o, clk_int_select, ST_INT); else n_pass++;
    $display("bringup: state=%0d select=%b", state_o, clk_int_select);
  endtask

  task automatic test_promotion;
    clk_ext_active = 1'b1;
    tick(10);
    n_checks++; if (using_ext !== 1'b0) $display("FAIL promo_early got=%b exp=0", using_ext); else n_pass++;
    clk_ext_active = 1'b0;   // one-cycle glitch restarts the window
    tick(1);
    clk_ext_active = 1'b1;
    tick(18);
    n_checks++; if (using_ext !== 1'b0 || state_o !== ST_INT) $display("FAIL promo_window18 got using_ext=%b state=%0d exp 0/%0d", using_ext, state_o, ST_INT); else n_pass++;
    tick(1);
    exp_sw = 1;
    n_checks++; if (using_ext !== 1'b1 || clk_int_select !== 1'b0 || state_o !== ST_EXT) $display("FAIL promo_ext got using_ext=%b select=%b state=%0d exp 1/0/%0d", using_ext, clk_int_select, state_o, ST_EXT); else n_pass++;
    n_checks++; if (switch_cnt !== sw_exp(exp_sw)) $display("FAIL promo_switch_cnt got=%0d exp=%0d", switch_cnt, sw_exp(exp_sw)); else n_pass++;
    $display("promotion: state=%0d select=%b switch_cnt=%0d", state_o, clk_int_select, switch_cnt);
  endtask

  task automatic test_failover;
    clk_ext_active = 1'b0;
    tick(2);
    n_checks++; if (clk_int_select !== 1'b0) $display("FAIL failover_latency2 got=%b exp=0", clk_int_select); else n_pass++;
    tick(1);
    exp_sw = 2;
    n_checks++; if (clk_int_select !== 1'b1 || state_o !== ST_INT) $display("FAIL failover_int got select=%b state=%0d exp 1/%0d", clk_int_select, state_o, ST_INT); else n_pass++;
    n_checks++; if (switch_cnt !== sw_exp(exp_sw)) $display("FAIL failover_switch_cnt got=%0d exp=%0d", switch_cnt, sw_exp(exp_sw)); else n_pass++;
    clk_ext_active = 1'b1;
    tick(18);
    n_checks++; if (state_o !== ST_INT) $display("FAIL failover_hysteresis got=%0d exp=%0d", state_o, ST_INT); else n_pass++;
    force_int = 1'b1;
    tick(40);
    n_checks++; if (state_o !== ST_INT || clk_int_select !== 1'b1) $display("FAIL force_int_hold got state=%0d select=%b exp %0d/1", state_o, clk_int_select, ST_INT); else n_pass++;
    force_int = 1'b0;
    tick(1);
    exp_sw = 3;
    n_checks++; if (state_o !== ST_EXT) $display("FAIL force_release_promote got=%0d exp=%0d", state_o, ST_EXT); else n_pass++;
    force_int = 1'b1;
    tick(1);
    exp_sw = 4;
    n_checks++; if (state_o !== ST_INT || clk_int_select !== 1'b1) $display("FAIL force_in_ext got state=%0d select=%b exp %0d/1", state_o, clk_int_select, ST_INT); else n_pass++;
    force_int = 1'b0;
    tick(16);
    n_checks++; if (state_o !== ST_INT) $display("FAIL force_window16 got=%0d exp=%0d", state_o, ST_INT); else n_pass++;
    tick(1);
    exp_sw = 5;
    n_checks++; if (state_o !== ST_EXT) $display("FAIL force_window17 got=%0d exp=%0d", state_o, ST_EXT); else n_pass++;
    n_checks++; if (switch_cnt !== sw_exp(exp_sw)) $display("FAIL force_switch_cnt got=%0d exp=%0d", switch_cnt, sw_exp(exp_sw)); else n_pass++;
    $display("failover: state=%0d switch_cnt=%0d", state_o, switch_cnt);
  endtask

  task automatic test_simultaneous;
    locked = 1'b0;
    clk_ext_active = 1'b0;
    tick(2);
    n_checks++; if (state_o !== ST_EXT) $display("FAIL simul_latency2 got=%0d exp=%0d", state_o, ST_EXT); else n_pass++;
    tick(1);
    n_checks++; if (state_o !== ST_RST || mmcm_rst_n !== 1'b0 || clk_int_select !== 1'b1) $display("FAIL simul_to_rst got state=%0d mmcm_rst_n=%b select=%b exp %0d/0/1", state_o, mmcm_rst_n, clk_int_select, ST_RST); else n_pass++;
    n_checks++; if (switch_cnt !== sw_exp(exp_sw)) $display("FAIL simul_switch_cnt got=%0d exp=%0d", switch_cnt, sw_exp(exp_sw)); else n_pass++;
    $display("simultaneous: state=%0d mmcm_rst_n=%b", state_o, mmcm_rst_n);
  endtask

  // Runs until fault or a cycle bound; each full attempt is 8 + 100 cycles.
  task automatic run_to_fault(input string tag);
    int   cyc;
    int   rises;
    logic prev;
    cyc = 0; rises = 0; prev = mmcm_rst_n;
    while (fault !== 1'b1 && cyc < 800) begin
      tick(1);
      cyc++;
      if (mmcm_rst_n === 1'b1 && prev === 1'b0) rises++;
      prev = mmcm_rst_n;
    end
    n_checks++; if (fault !== 1'b1 || state_o !== ST_FAULT) $display("FAIL %s_fault got fault=%b state=%0d exp 1/%0d", tag, fault, state_o, ST_FAULT); else n_pass++;
    n_checks++; if (rises !== 3) $display("FAIL %s_pulses got=%0d exp=3", tag, rises); else n_pass++;
    n_checks++; if (cyc !== 324) $display("FAIL %s_cycles got=%0d exp=324", tag, cyc); else n_pass++;
    n_checks++; if (mmcm_rst_n !== 1'b1 || clk_int_select !== 1'b1) $display("FAIL %s_outputs got mmcm_rst_n=%b select=%b exp 1/1", tag, mmcm_rst_n, clk_int_select); else n_pass++;
    $display("%s: cycles=%0d pulses=%0d fault=%b", tag, cyc, rises, fault);
  endtask

  task automatic test_lock_timeout;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_sw = 0;
    run_to_fault("timeout");
    tick(5);
    n_checks++; if (state_o !== ST_FAULT) $display("FAIL fault_sticky got=%0d exp=%0d", state_o, ST_FAULT); else n_pass++;
    retry = 1'b1;
    tick(1);
    retry = 1'b0;
    n_checks++; if (state_o !== ST_RST || fault !== 1'b0 || mmcm_rst_n !== 1'b0) $display("FAIL retry_exit got state=%0d fault=%b mmcm_rst_n=%b exp %0d/0/0", state_o, fault, mmcm_rst_n, ST_RST); else n_pass++;
    // a cleared retry counter grants the full set of attempts again
    run_to_fault("retry_rerun");
    n_checks++; if (switch_cnt !== sw_exp(exp_sw)) $display("FAIL timeout_switch_cnt got=%0d exp=%0d", switch_cnt, sw_exp(exp_sw)); else n_pass++;
  endtask

  task automatic test_async_reset;
    retry = 1'b1;
    tick(1);
    retry = 1'b0;
    tick(10);
    n_checks++; if (state_o !== ST_LOCK || mmcm_rst_n !== 1'b1) $display("FAIL async_pre got state=%0d mmcm_rst_n=%b exp %0d/1", state_o, mmcm_rst_n, ST_LOCK); else n_pass++;
    #2;
    rst = 1'b1;
    #2;
    n_checks++; if (state_o !== ST_RST || mmcm_rst_n !== 1'b0 || clk_int_select !== 1'b1) $display("FAIL async_rst got state=%0d mmcm_rst_n=%b select=%b exp %0d/0/1", state_o, mmcm_rst_n, clk_int_select, ST_RST); else n_pass++;
    n_checks++; if (using_ext !== 1'b0 || fault !== 1'b0 || switch_cnt !== 16'd0) $display("FAIL async_flags got using_ext=%b fault=%b switch_cnt=%0d exp 0/0/0", using_ext, fault, switch_cnt); else n_pass++;
    $display("async_reset: state=%0d mmcm_rst_n=%b", state_o, mmcm_rst_n);
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_promotion();
    test_failover();
    test_simultaneous();
    test_lock_timeout();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_clk_src_ctrl
